// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state encoding and LED codes for the counter controller
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

    localparam logic [3:0] LED_CLEAR = 4'b0000;
    localparam logic [3:0] LED_IDLE  = 4'b0001;
    localparam logic [3:0] LED_RUN   = 4'b0010;
    localparam logic [3:0] LED_PAUSE = 4'b0100;
    localparam logic [3:0] LED_DONE  = 4'b1000;

    function automatic logic [3:0] led_code(input ctrl_state_t s);
        logic [3:0] code;
        code = LED_CLEAR;
        case (s)
            ST_IDLE:  code = LED_IDLE;
            ST_RUN:   code = LED_RUN;
            ST_PAUSE: code = LED_PAUSE;
            ST_DONE:  code = LED_DONE;
            default:  code = LED_CLEAR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchronizer followed by a stable-count debouncer
module sw_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // The counter runs only while the synchronized input disagrees with the
    // accepted level; any agreeing sample restarts the qualification window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - run/pause/clear controller driving an external 4-bit counter
module counter_ctrl
    import ctrl_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int TARGET   = 10,
    parameter int DEBOUNCE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] switches,
    input  logic [3:0] counter_out,
    output logic       cnt_rst,
    output logic       cnt_en,
    output logic [3:0] leds,
    output logic       done
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    localparam logic [3:0]  TGT      = 4'(TARGET);

    ctrl_state_t r_state;
    ctrl_state_t w_next;
    logic [15:0] r_presc;
    logic [3:0]  r_leds;
    logic        r_done;
    logic        w_run;
    logic        w_clear;
    logic        w_tick;
    logic        w_below;
    logic        w_cnt_en;
    logic        w_cnt_rst;

    sw_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_run (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (switches[0]),
        .o_level (w_run)
    );

    sw_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (switches[1]),
        .o_level (w_clear)
    );

    assign w_tick  = (r_presc == PRE_LAST);
    assign w_below = (counter_out < TGT);

    always_comb begin
        w_next    = r_state;
        w_cnt_en  = 1'b0;
        w_cnt_rst = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_rst = 1'b1;
                w_next    = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_run) w_next = ST_RUN;
            end
            ST_RUN: begin
                // Gating on w_below keeps the counter from ever stepping past TARGET.
                w_cnt_en = w_tick && w_below;
                if (!w_below)   w_next = ST_DONE;
                else if (!w_run) w_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (w_run) w_next = ST_RUN;
            end
            ST_DONE: begin
                w_next = ST_DONE;
            end
            default: begin
                w_next = ST_CLEAR;
            end
        endcase
        if (w_clear && (r_state != ST_CLEAR)) w_next = ST_CLEAR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_presc <= '0;
        end else if (r_state == ST_RUN) begin
            r_presc <= w_tick ? 16'd0 : (r_presc + 16'd1);
        end
    end

    // Display registers load from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds <= LED_CLEAR;
            r_done <= 1'b0;
        end else begin
            r_leds <= led_code(w_next);
            r_done <= (w_next == ST_DONE);
        end
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign cnt_en  = w_cnt_en;
    assign cnt_rst = w_cnt_rst;
    assign leds    = r_leds;
    assign done    = r_done;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - directed bench for counter_ctrl with attached counter models
module tb_counter_ctrl;

    localparam int DB = 4;
    localparam logic [3:0] L_CLEAR = 4'b0000;
    localparam logic [3:0] L_IDLE  = 4'b0001;
    localparam logic [3:0] L_RUN   = 4'b0010;
    localparam logic [3:0] L_PAUSE = 4'b0100;
    localparam logic [3:0] L_DONE  = 4'b1000;

    typedef struct {
        logic [1:0] sw;
        int         hold;
        logic [3:0] leds;
        logic       done;
        logic [7:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [1:0] sw_a, sw_b;
    logic [7:0] cnt_a = '0;
    logic [7:0] cnt_b = '0;
    logic       cnt_rst_a, cnt_en_a, done_a;
    logic       cnt_rst_b, cnt_en_b, done_b;
    logic [3:0] leds_a, leds_b;
    int         viol_a = 0;
    int         viol_b = 0;
    int         n_pass = 0;
    int         n_total = 0;
    vec_t       vecs [8];

    always #5 clk = ~clk;

    counter_ctrl #(.PRESCALE(4), .TARGET(10), .DEBOUNCE(DB)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_a),
        .switches    (sw_a),
        .counter_out (cnt_a[3:0]),
        .cnt_rst     (cnt_rst_a),
        .cnt_en      (cnt_en_a),
        .leds        (leds_a),
        .done        (done_a)
    );

    counter_ctrl #(.PRESCALE(1), .TARGET(10), .DEBOUNCE(DB)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_b),
        .switches    (sw_b),
        .counter_out (cnt_b[3:0]),
        .cnt_rst     (cnt_rst_b),
        .cnt_en      (cnt_en_b),
        .leds        (leds_b),
        .done        (done_b)
    );

    always @(posedge clk) begin
        if (cnt_rst_a)     cnt_a <= '0;
        else if (cnt_en_a) cnt_a <= cnt_a + 8'd1;
        if (cnt_en_a && (cnt_rst_a || leds_a != L_RUN)) viol_a <= viol_a + 1;
    end

    always @(posedge clk) begin
        if (cnt_rst_b)     cnt_b <= '0;
        else if (cnt_en_b) cnt_b <= cnt_b + 8'd1;
        if (cnt_en_b && (cnt_rst_b || leds_b != L_RUN)) viol_b <= viol_b + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_leds(input bit use_b, input logic [3:0] want, input int max, input string name);
        int n = 0;
        while ((use_b ? leds_b : leds_a) !== want && n < max) begin
            step(1);
            n++;
        end
        chk(name, use_b ? leds_b : leds_a, want);
    endtask

    initial begin
        int bad;
        int saw_run;
        int n_en;
        int first;
        int last;

        vecs[0] = '{2'b00, 20, L_IDLE,  1'b0, 8'd0};
        vecs[1] = '{2'b01, 20, L_RUN,   1'b0, 8'd3};
        vecs[2] = '{2'b00, 20, L_PAUSE, 1'b0, 8'd5};
        vecs[3] = '{2'b01, 60, L_DONE,  1'b1, 8'd10};
        vecs[4] = '{2'b00, 20, L_DONE,  1'b1, 8'd10};
        vecs[5] = '{2'b01, 20, L_DONE,  1'b1, 8'd10};
        vecs[6] = '{2'b10,  3, L_DONE,  1'b1, 8'd10};
        vecs[7] = '{2'b00, 20, L_DONE,  1'b1, 8'd10};

        rst_a = 1'b0;
        rst_b = 1'b0;
        sw_a  = 2'b00;
        sw_b  = 2'b00;
        step(3);
        chk("rst_leds",    leds_a,    L_CLEAR);
        chk("rst_cnt_rst", cnt_rst_a, 1'b1);
        chk("rst_cnt_en",  cnt_en_a,  1'b0);
        chk("rst_done",    done_a,    1'b0);

        rst_a = 1'b1;
        chk("clear_cycle_cnt_rst", cnt_rst_a, 1'b1);
        step(1);
        chk("idle_leds",    leds_a,    L_IDLE);
        chk("idle_cnt_rst", cnt_rst_a, 1'b0);
        step(29);
        chk("idle_hold_leds", leds_a, L_IDLE);
        chk("idle_no_pulse",  cnt_a,  8'd0);

        for (int i = 0; i < 8; i++) begin
            sw_a = vecs[i].sw;
            step(vecs[i].hold);
            chk($sformatf("vec%0d_leds", i), leds_a, vecs[i].leds);
            chk($sformatf("vec%0d_done", i), done_a, vecs[i].done);
            chk($sformatf("vec%0d_cnt",  i), cnt_a,  vecs[i].cnt);
        end

        // pause/resume with prescaler held mid-period
        rst_a = 1'b0;
        step(2);
        rst_a = 1'b1;
        step(2);
        chk("s2_idle", leds_a, L_IDLE);
        chk("s2_cnt0", cnt_a,  8'd0);
        sw_a = 2'b01;
        step(DB + 2);
        chk("deb_not_early", leds_a, L_IDLE);
        step(1);
        chk("deb_exact", leds_a, L_RUN);
        step(3);
        sw_a = 2'b00;
        wait_leds(1'b0, L_PAUSE, 20, "pause_enter");
        chk("pause_cnt", cnt_a, 8'd2);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (leds_a !== L_PAUSE || cnt_en_a !== 1'b0) bad++;
        end
        chk("pause_hold", bad, 0);
        sw_a = 2'b01;
        wait_leds(1'b0, L_RUN, 20, "resume");
        chk("resume_first", cnt_en_a, 1'b0);
        step(1);
        chk("resume_second", cnt_en_a, 1'b1);

        // run and clear accepted together from PAUSE
        sw_a = 2'b00;
        wait_leds(1'b0, L_PAUSE, 20, "s3_pause");
        sw_a = 2'b11;
        saw_run = 0;
        for (int i = 0; i < 20 && cnt_rst_a !== 1'b1; i++) begin
            step(1);
            if (leds_a === L_RUN) saw_run = 1;
        end
        chk("clr_prio", saw_run, 0);
        chk("clr_pulse", cnt_rst_a, 1'b1);
        chk("clr_leds", leds_a, L_CLEAR);
        step(1);
        chk("clr_then_idle", leds_a, L_IDLE);
        chk("clr_cnt", cnt_a, 8'd0);
        sw_a = 2'b01;
        wait_leds(1'b0, L_RUN, 40, "clr_then_run");
        chk("clr_run_done", done_a, 1'b0);

        // PRESCALE=1 instance: async reset mid-pulse, then a full run
        rst_b = 1'b1;
        step(2);
        chk("b_idle", leds_b, L_IDLE);
        sw_b = 2'b01;
        wait_leds(1'b1, L_RUN, 20, "b_run");
        chk("b_en_first", cnt_en_b, 1'b1);
        step(3);
        chk("b_en_mid", cnt_en_b, 1'b1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("b_rst_en",      cnt_en_b,  1'b0);
        chk("b_rst_cnt_rst", cnt_rst_b, 1'b1);
        chk("b_rst_leds",    leds_b,    L_CLEAR);
        step(2);
        rst_b = 1'b1;
        step(1);
        chk("b_cnt_cleared", cnt_b, 8'd0);
        wait_leds(1'b1, L_RUN, 20, "b_rerun");
        n_en = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < 30; i++) begin
            if (cnt_en_b === 1'b1) begin
                n_en++;
                if (first < 0) first = i;
                last = i;
            end
            step(1);
        end
        chk("b_pulses",      n_en,        10);
        chk("b_consecutive", last - first, 9);
        chk("b_done_leds",   leds_b,      L_DONE);
        chk("b_done",        done_b,      1'b1);
        chk("b_cnt",         cnt_b,       8'd10);

        chk("a_en_rules", viol_a, 0);
        chk("b_en_rules", viol_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
